// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: button count, one-hot
// press codes and the per-bit debounce state encoding.
package button_pkg;

    localparam int NUM_BTN = 4;

    localparam logic [NUM_BTN-1:0] BTN_NONE = 4'b0000;
    localparam logic [NUM_BTN-1:0] BTN0     = 4'b0001;
    localparam logic [NUM_BTN-1:0] BTN1     = 4'b0010;
    localparam logic [NUM_BTN-1:0] BTN2     = 4'b0100;
    localparam logic [NUM_BTN-1:0] BTN3     = 4'b1000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One button bit: 2-FF synchroniser followed by a debounce FSM that flips the
// level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_cell
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        case (r_state)
            STABLE_LO, STABLE_HI: begin
                if (r_sync2 != r_level) begin
                    w_state_nxt = (r_state == STABLE_LO) ? CHK_HI : CHK_LO;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            CHK_HI, CHK_LO: begin
                // A single agreeing sample is treated as bounce and restarts the count.
                if (r_sync2 == r_level) begin
                    w_state_nxt = (r_state == CHK_HI) ? STABLE_LO : STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = (r_state == CHK_HI) ? STABLE_HI : STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_level_nxt = ~r_level;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign btn_level = r_level;

endmodule

// File: rtl/button_conditioner.sv
// Debounces four raw buttons and emits one-hot single-cycle press pulses with
// lowest-index arbitration. Optional auto-repeat: define BTN_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 200000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] control,
    output logic [3:0] btn_level,
    output logic       drop_pulse
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] r_level_d;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_req;
    logic [NUM_BTN-1:0] w_grant;
    logic               w_drop;
    logic [NUM_BTN-1:0] r_control;
    logic               r_drop;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .btn_raw  (btn_raw[g]),
            .btn_level(w_level[g])
        );
    end

    assign w_rise = w_level & ~r_level_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0]   r_rpt_tmr [NUM_BTN];
    logic [NUM_BTN-1:0] r_rpt_phase;
    logic [NUM_BTN-1:0] w_rpt_fire;

    // Timer holds cycles since the last pulse request; phase selects first-delay vs period.
    always_comb begin
        w_rpt_fire = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            w_rpt_fire[i] = w_level[i] &&
                (r_rpt_tmr[i] == (r_rpt_phase[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                r_rpt_tmr[i] <= '0;
            end
            r_rpt_phase <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (!w_level[i]) begin
                    r_rpt_tmr[i]   <= '0;
                    r_rpt_phase[i] <= 1'b0;
                end else if (w_rise[i]) begin
                    r_rpt_tmr[i]   <= RPT_W'(1);
                    r_rpt_phase[i] <= 1'b0;
                end else if (w_rpt_fire[i]) begin
                    r_rpt_tmr[i]   <= RPT_W'(1);
                    r_rpt_phase[i] <= 1'b1;
                end else begin
                    r_rpt_tmr[i]   <= r_rpt_tmr[i] + RPT_W'(1);
                end
            end
        end
    end

    assign w_req = w_rise | w_rpt_fire;
`else
    assign w_req = w_rise;
`endif

    always_comb begin
        w_grant = BTN_NONE;
        if (w_req[0]) begin
            w_grant = BTN0;
        end else if (w_req[1]) begin
            w_grant = BTN1;
        end else if (w_req[2]) begin
            w_grant = BTN2;
        end else if (w_req[3]) begin
            w_grant = BTN3;
        end
        w_drop = |(w_req & ~w_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= '0;
            r_control <= BTN_NONE;
            r_drop    <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_control <= w_grant;
            r_drop    <= w_drop;
        end
    end

    assign control    = r_control;
    assign btn_level  = w_level;
    assign drop_pulse = r_drop;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a run-length debounce model
// and arithmetic repeat schedule; define BTN_AUTOREPEAT_EN to cover auto-repeat.
module tb_button_conditioner;

    localparam int D  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RP = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] control;
    logic [3:0] btn_level;
    logic       drop_pulse;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .control   (control),
        .btn_level (btn_level),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: values expected right after the most recent edge.
    logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl2 = '0, m_ctrl = '0;
    logic       m_drop = 1'b0;
    int         m_run [4];
    int         edge_n = 0;
`ifdef BTN_AUTOREPEAT_EN
    int         m_t0 [4];

    function automatic int exp_pulses(input int hold);
        int t, last, c;
        t = D + 2;
        last = hold + 1 + D;
        c = 1;
        if (last >= t + RD) c += 1 + (last - t - RD) / RP;
        return c;
    endfunction
`endif

    task automatic tick();
        logic [3:0] cand, nl;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl2 = '0; m_ctrl = '0; m_drop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                m_t0[i] = -1;
`endif
            end
        end else begin
            cand = m_lvl & ~m_lvl2;
`ifdef BTN_AUTOREPEAT_EN
            for (int i = 0; i < 4; i++) begin
                if (!m_lvl[i]) m_t0[i] = -1;
                else if (cand[i]) m_t0[i] = edge_n;
                else if (m_t0[i] >= 0) begin
                    int d;
                    d = edge_n - m_t0[i];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) cand[i] = 1'b1;
                end
            end
`endif
            m_ctrl = '0;
            m_drop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (cand[i] && m_ctrl == 4'b0000) m_ctrl[i] = 1'b1;
                else if (cand[i]) m_drop = 1'b1;
            end
            nl = m_lvl;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_lvl2 = m_lvl;
            m_lvl  = nl;
            m_s2   = m_s1;
            m_s1   = btn_raw;
        end
    endtask

    task automatic test_reset();
        btn_raw = 4'b1111;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (control !== 4'b0000 || btn_level !== 4'b0000 || drop_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold j=%0d control=%b level=%b drop=%b required 0000 0000 0", j, control, btn_level, drop_pulse);
            end
        end
        rst = 1'b0;
        for (int j = 0; j < D + 1; j++) begin
            tick();
            checks++;
            if (control !== 4'b0000 || btn_level !== 4'b0000 || drop_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_release j=%0d control=%b level=%b drop=%b required 0000 0000 0", j, control, btn_level, drop_pulse);
            end
        end
        for (int j = 0; j < 2 * D + 14; j++) begin
            if (j == 4) btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL reset_settle j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
        end
    endtask

    task automatic test_clean_press();
        int first_lvl = -1, pulse_at = -1, npulse = 0, exp_n;
        localparam int HOLD = 30;
`ifdef BTN_AUTOREPEAT_EN
        exp_n = exp_pulses(HOLD);
`else
        exp_n = 1;
`endif
        btn_raw = 4'b0010;
        for (int j = 0; j < HOLD + D + 6; j++) begin
            if (j == HOLD) btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL clean_press j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
            if (btn_level[1] === 1'b1 && first_lvl < 0) first_lvl = j;
            if (control === 4'b0010) begin
                npulse++;
                if (pulse_at < 0) pulse_at = j;
            end
        end
        checks++;
        if (first_lvl != D + 1) begin
            errors++;
            $display("FAIL clean_level_latency got %0d required %0d", first_lvl, D + 1);
        end
        checks++;
        if (pulse_at != D + 2) begin
            errors++;
            $display("FAIL clean_pulse_latency got %0d required %0d", pulse_at, D + 2);
        end
        checks++;
        if (npulse != exp_n) begin
            errors++;
            $display("FAIL clean_pulse_count got %0d required %0d", npulse, exp_n);
        end
    endtask

    task automatic test_bounce();
        int pulse_at = -1, npulse = 0, exp_n;
`ifdef BTN_AUTOREPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        for (int j = 0; j < 46; j++) begin
            if (j < 8) btn_raw = ((j / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
            else if (j < 28) btn_raw = 4'b0001;
            else if (j < 36) btn_raw = ((j / 2) % 2 == 0) ? 4'b0000 : 4'b0001;
            else btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL bounce j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
            if (control !== 4'b0000) begin
                npulse++;
                if (pulse_at < 0) pulse_at = j;
            end
        end
        checks++;
        if (pulse_at != 8 + D + 2) begin
            errors++;
            $display("FAIL bounce_first_pulse got %0d required %0d", pulse_at, 8 + D + 2);
        end
        checks++;
        if (npulse != exp_n) begin
            errors++;
            $display("FAIL bounce_pulse_count got %0d required %0d", npulse, exp_n);
        end
    endtask

    task automatic test_simultaneous();
        int n0100 = 0, n1000 = 0, first_ok = 0, exp_n;
        localparam int HOLD = 20;
`ifdef BTN_AUTOREPEAT_EN
        exp_n = exp_pulses(HOLD);
`else
        exp_n = 1;
`endif
        btn_raw = 4'b1100;
        for (int j = 0; j < HOLD + D + 6; j++) begin
            if (j == HOLD) btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL simultaneous j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
            if (j == D + 2 && control === 4'b0100 && drop_pulse === 1'b1) first_ok = 1;
            if (control === 4'b0100) n0100++;
            if (control === 4'b1000) n1000++;
        end
        checks++;
        if (first_ok != 1) begin
            errors++;
            $display("FAIL simul_first got %0d required 1", first_ok);
        end
        checks++;
        if (n1000 != 0) begin
            errors++;
            $display("FAIL simul_loser_pulses got %0d required 0", n1000);
        end
        checks++;
        if (n0100 != exp_n) begin
            errors++;
            $display("FAIL simul_winner_count got %0d required %0d", n0100, exp_n);
        end
    endtask

    task automatic test_reset_midcount();
        int npulse = 0, nlevel = 0;
        btn_raw = 4'b0001;
        for (int j = 0; j < 16; j++) begin
            rst = (j == 3);
            if (j == 6) btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL reset_mid j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
            if (control !== 4'b0000) npulse++;
            if (btn_level !== 4'b0000) nlevel++;
        end
        rst = 1'b0;
        checks++;
        if (npulse != 0 || nlevel != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet pulses=%0d level_cycles=%0d required 0 0", npulse, nlevel);
        end
    endtask

    task automatic test_held_button();
        int npulse = 0, exp_n, first = -1;
        localparam int HOLD = 40;
`ifdef BTN_AUTOREPEAT_EN
        int second = -1;
        exp_n = exp_pulses(HOLD);
`else
        exp_n = 1;
`endif
        btn_raw = 4'b1000;
        for (int j = 0; j < HOLD + D + 8; j++) begin
            if (j == HOLD) btn_raw = 4'b0000;
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL held j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
            if (control === 4'b1000) begin
                npulse++;
`ifdef BTN_AUTOREPEAT_EN
                if (first >= 0 && second < 0) second = j;
`endif
                if (first < 0) first = j;
            end
        end
        checks++;
        if (npulse != exp_n || first != D + 2) begin
            errors++;
            $display("FAIL held_pulses count=%0d first=%0d required %0d %0d", npulse, first, exp_n, D + 2);
        end
`ifdef BTN_AUTOREPEAT_EN
        checks++;
        if (second - first != RD) begin
            errors++;
            $display("FAIL held_repeat_delay got %0d required %0d", second - first, RD);
        end
`endif
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
            end
            rst = ($urandom_range(120) == 0);
            tick();
            checks++;
            if (control !== m_ctrl || btn_level !== m_lvl || drop_pulse !== m_drop) begin
                errors++;
                $display("FAIL random j=%0d control=%b/%b level=%b/%b drop=%b/%b", j, control, m_ctrl, btn_level, m_lvl, drop_pulse, m_drop);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
            m_t0[i] = -1;
`endif
        end
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_held_button();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
